// File: rtl/serial_comp_ctrl.sv
// Bit-serial magnitude comparator: one GT/EQ/LT slice walked MSB-first over a WIDTH-bit pair.
// Define SIGNED_CMP_EN to treat the operands as two's complement (sign bit swapped into the slice).
module serial_comp_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxMax = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IdxW-1:0]  idx_q;
    logic             g_q;
    logic             e_q;
    logic             l_q;

    logic bit_a;
    logic bit_b;
    logic slice_gt;
    logic slice_eq;
    logic slice_lt;

    // Slice inputs and the single comparator slice shared across all bit positions.
    always_comb begin
`ifdef SIGNED_CMP_EN
        // A set sign bit means the smaller operand, so the sign pair is fed swapped.
        if (idx_q == IdxMax) begin
            bit_a = b_q[idx_q];
            bit_b = a_q[idx_q];
        end else begin
            bit_a = a_q[idx_q];
            bit_b = b_q[idx_q];
        end
`else
        bit_a = a_q[idx_q];
        bit_b = b_q[idx_q];
`endif
        slice_gt = g_q | (bit_a & ~bit_b & e_q);
        slice_eq = e_q & ~(bit_a ^ bit_b);
        slice_lt = l_q | (~bit_a & bit_b & e_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
            l_q     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle, StFin: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        g_q     <= 1'b0;
                        e_q     <= 1'b1;
                        l_q     <= 1'b0;
                        idx_q   <= IdxMax;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    g_q <= slice_gt;
                    e_q <= slice_eq;
                    l_q <= slice_lt;
                    if (idx_q == '0) begin
                        gt      <= slice_gt;
                        eq      <= slice_eq;
                        lt      <= slice_lt;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StFin;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Randomised self-checking bench for serial_comp_ctrl (WIDTH=8) against a plain-arithmetic model.
module tb_serial_comp_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy;
    logic         done;
    logic         gt;
    logic         eq;
    logic         lt;

    int checks = 0;
    int errors = 0;

    serial_comp_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a_in (a_in),
        .b_in (b_in),
        .busy (busy),
        .done (done),
        .gt   (gt),
        .eq   (eq),
        .lt   (lt)
    );

    always #5 clk = ~clk;

    // {gt, eq, lt} from ordinary integer comparison of the two operands.
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia;
        int ib;
`ifdef SIGNED_CMP_EN
        ia = int'($signed(a));
        ib = int'($signed(b));
`else
        ia = int'(a);
        ib = int'(b);
`endif
        if (ia > ib) return 3'b100;
        if (ia < ib) return 3'b001;
        return 3'b010;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, scramble the inputs afterwards, and check latency, result and hold.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        int lat;
        logic [2:0] exp;
        exp = model(a, b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_accept: got %b expected 1", name, busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 50) begin
            tick();
            lat++;
            a_in = W'($urandom);
            b_in = W'($urandom);
        end
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, W);
        end
        checks++;
        if ({gt, eq, lt} !== exp) begin
            errors++;
            $display("FAIL %s result a=%0h b=%0h: got %b expected %b", name, a, b, {gt, eq, lt}, exp);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {gt, eq, lt} !== exp) begin
            errors++;
            $display("FAIL %s hold: got done=%b busy=%b res=%b expected done=0 busy=0 res=%b",
                     name, done, busy, {gt, eq, lt}, exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, gt, eq, lt} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected 00000", {busy, done, gt, eq, lt});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, done, gt, eq, lt} !== 5'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 00000", {busy, done, gt, eq, lt});
        end
    endtask

    task automatic test_directed;
        run_op(8'h5A, 8'h5A, "equal_5a");
        run_op(8'h03, 8'h04, "lt_03_04");
        run_op(8'hFF, 8'h00, "ff_00");
        run_op(8'h80, 8'h7F, "80_7f");
        run_op(8'h00, 8'h00, "zero_zero");
        run_op(8'h00, 8'hFF, "00_ff");
    endtask

    task automatic test_random;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = (i % 5 == 0) ? a : W'($urandom);
            run_op(a, b, "random");
            checks++;
            if ((gt + eq + lt) !== 1) begin
                errors++;
                $display("FAIL onehot: got %b expected exactly one bit", {gt, eq, lt});
            end
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        logic [2:0] exp;
        exp = model(8'h03, 8'h04);
        a_in  = 8'h03;
        b_in  = 8'h04;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        lat   = 2;
        a_in  = 8'hFF;
        b_in  = 8'h00;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            lat++;
        end
        start = 1'b0;
        while (done !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL start_ignored latency: got %0d expected %0d", lat, W);
        end
        checks++;
        if ({gt, eq, lt} !== exp) begin
            errors++;
            $display("FAIL start_ignored result: got %b expected %b", {gt, eq, lt}, exp);
        end
        tick();
    endtask

    task automatic test_reset_mid_run;
        bit saw_done;
        a_in  = 8'hC3;
        b_in  = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, gt, eq, lt} !== 5'b0) begin
            errors++;
            $display("FAIL mid_run_reset: got %b expected 00000", {busy, done, gt, eq, lt});
        end
        saw_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abandoned_op: got done/busy activity expected none");
        end
        run_op(8'hC3, 8'h3C, "rerun_after_reset");
    endtask

    task automatic test_back_to_back;
        int gap;
        logic [2:0] exp;
        exp = model(8'h10, 8'h20);
        a_in  = 8'h9E;
        b_in  = 8'h41;
        start = 1'b1;
        tick();
        start = 1'b0;
        gap = 0;
        while (done !== 1'b1 && gap < 50) begin
            tick();
            gap++;
        end
        checks++;
        if ({gt, eq, lt} !== model(8'h9E, 8'h41)) begin
            errors++;
            $display("FAIL b2b first result: got %b expected %b", {gt, eq, lt}, model(8'h9E, 8'h41));
        end
        // Now in the FIN cycle: request the next operation immediately.
        a_in  = 8'h10;
        b_in  = 8'h20;
        start = 1'b1;
        tick();
        start = 1'b0;
        gap = 1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b accept_in_fin: got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        while (done !== 1'b1 && gap < 50) begin
            tick();
            gap++;
        end
        checks++;
        if (gap !== W + 1) begin
            errors++;
            $display("FAIL b2b done_gap: got %0d expected %0d", gap, W + 1);
        end
        checks++;
        if ({gt, eq, lt} !== exp) begin
            errors++;
            $display("FAIL b2b second result: got %b expected %b", {gt, eq, lt}, exp);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
